// File: rtl/int_to_fp_norm.sv
// int_to_fp_norm: converts a two's-complement integer into the simplified
// float format {sign, exp, frac}, value = (-1)^sign * 0.frac * 2^exp.
// Normalization shifts the magnitude left one bit per clock until frac[MSB]
// is set. Valid/ready handshakes are used on both the input and the output.
module int_to_fp_norm #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8,
  parameter int EXP_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INT_W-1:0]        int_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [EXP_W+FRAC_W:0]   fp_out,
  output logic                    out_zero,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(INT_W);

  state_t              state;
  logic                sign;
  logic [FRAC_W-1:0]   mant;
  logic [EXP_W-1:0]    exp_r;

  logic [INT_W-1:0]    mag;
  logic [FRAC_W-1:0]   mant_shl;
  logic [EXP_W-1:0]    exp_dec;

  // Magnitude of the input and next-step values for normalization.
  // The magnitude of the most negative input wraps to 2^(INT_W-1), which is
  // already normalized.
  always_comb begin
    mag      = int_in[INT_W-1] ? ('0 - int_in) : int_in;
    mant_shl = {mant[FRAC_W-2:0], 1'b0};
    exp_dec  = exp_r - EXP_W'(1);
  end

  // Input is accepted only in IDLE, and never while reset is asserted.
  always_comb begin
    in_ready = (state == IDLE) && !reset;
  end

  // Control FSM with registered result and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mant      <= '0;
      exp_r     <= '0;
      fp_out    <= '0;
      out_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= int_in[INT_W-1];
            mant  <= mag;
            exp_r <= EXP_INIT;
            if (mag == '0) begin
              fp_out    <= '0;
              out_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (mag[INT_W-1]) begin
              fp_out    <= {int_in[INT_W-1], EXP_INIT, mag};
              out_zero  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              out_zero  <= 1'b0;
              state     <= NORM;
            end
          end
        end
        NORM: begin
          mant  <= mant_shl;
          exp_r <= exp_dec;
          if (mant_shl[FRAC_W-1]) begin
            fp_out    <= {sign, exp_dec, mant_shl};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_norm.sv
// Self-checking bench for int_to_fp_norm using a scoreboard queue.
module tb_int_to_fp_norm;

  logic        clk;
  logic        reset;
  logic [7:0]  int_in;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] fp_out;
  logic        out_zero;
  logic        out_valid;
  logic        out_ready;

  int passed;
  int total;

  typedef struct {
    logic [7:0]  v;
    logic [12:0] fp;
    logic        z;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  int_to_fp_norm #(
    .INT_W (8),
    .FRAC_W(8),
    .EXP_W (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .int_in   (int_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fp_out   (fp_out),
    .out_zero (out_zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference: locate the leading one, scale it to frac[7], exp = position + 1.
  task automatic model(input logic [7:0] v, output exp_t e);
    logic [7:0] m;
    int p;
    m = v[7] ? (8'd0 - v) : v;
    e.v = v;
    if (m == 8'd0) begin
      e.fp  = 13'd0;
      e.z   = 1'b1;
      e.lat = 1;
    end else begin
      p = 7;
      while (!m[p]) p--;
      e.fp  = {v[7], 4'(p + 1), 8'(m << (7 - p))};
      e.z   = 1'b0;
      e.lat = 8 - p;
    end
  endtask

  // Decode as the downstream fp_to_int stage would: frac * 2^exp / 256.
  function automatic int decode(input logic [12:0] f);
    int mag;
    mag = (int'(f[7:0]) << f[11:8]) >>> 8;
    return f[12] ? -mag : mag;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] v, input logic ready_now);
    exp_t e;
    @(negedge clk);
    wait_idle();
    int_in    = v;
    in_valid  = 1'b1;
    out_ready = ready_now;
    @(posedge clk);
    model(v, e);
    exp_q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input logic [7:0] v, input int hold);
    exp_t e;
    logic [12:0] held;
    int cycles;
    send(v, hold == 0);
    @(negedge clk);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    e = exp_q.pop_front();
    check("fp_out", {19'd0, fp_out}, {19'd0, e.fp});
    check("out_zero", {31'd0, out_zero}, {31'd0, e.z});
    check("latency", cycles, e.lat);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    check("roundtrip", decode(fp_out), int'($signed(v)));
    held = fp_out;
    for (int i = 0; i < hold; i++) begin
      int_in   = 8'h05;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_fp", {19'd0, fp_out}, {19'd0, held});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b1;
    int_in    = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_fp", {19'd0, fp_out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_zero", {31'd0, out_zero}, 32'd0);
    reset = 1'b0;
    #1 check("rst_release_ready", {31'd0, in_ready}, 32'd1);

    run(8'h24, 0);
    run(8'h81, 0);
    run(8'h80, 0);
    run(8'h01, 0);
    run(8'hFF, 0);
    run(8'h00, 0);
    run(8'h7F, 0);
    run(8'h24, 5);

    // Abort a long normalization with reset partway through.
    send(8'h01, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_back());
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_fp", {19'd0, fp_out}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1 check("abort_release_ready", {31'd0, in_ready}, 32'd1);
    run(8'h02, 0);

    for (int k = 0; k < 256; k++) begin
      run(8'(k), int'($urandom_range(0, 2)));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
